// File: rtl/inst_mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : inst_mm_pkg
// Description : Shared types, exception codes and load/store helpers for the
//               memory-access pipeline stage (inst_mm) and its request gen.
// Revision    : 1.0 - initial release
// ============================================================================
package inst_mm_pkg;

    typedef logic [31:0] uint32_t;

    // Architectural exception codes raised by the memory stage
    localparam logic [4:0] EXC_ADEL = 5'd4;   // address error on load
    localparam logic [4:0] EXC_ADES = 5'd5;   // address error on store

    typedef enum logic [4:0] {
        OP_NOP  = 5'd0,
        OP_ADDU = 5'd1,
        OP_SUBU = 5'd2,
        OP_OR   = 5'd3,
        OP_LUI  = 5'd4,
        OP_LB   = 5'd5,
        OP_LBU  = 5'd6,
        OP_LH   = 5'd7,
        OP_LHU  = 5'd8,
        OP_LW   = 5'd9,
        OP_SB   = 5'd10,
        OP_SH   = 5'd11,
        OP_SW   = 5'd12
    } op_t;

    typedef enum logic [1:0] {
        MSZ_NONE = 2'd0,
        MSZ_BYTE = 2'd1,
        MSZ_HALF = 2'd2,
        MSZ_WORD = 2'd3
    } mem_size_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } mm_state_t;

    typedef struct packed {
        op_t op;
    } decode_resp_t;

    typedef struct packed {
        logic       we;
        logic [4:0] waddr;
        uint32_t    wrdata;
    } regs_wreq_t;

    typedef struct packed {
        uint32_t pc;
        uint32_t inst;
    } inst_fetch_t;

    typedef struct packed {
        logic         valid;
        decode_resp_t decode_resp;
        regs_wreq_t   regs_wreq;
        uint32_t      mem_vaddr;
        uint32_t      mem_wrdata;   // rt operand for stores
        inst_fetch_t  inst_fetch;
    } pipe_ex_t;

    typedef struct packed {
        logic        valid;
        op_t         op;
        regs_wreq_t  regs_wreq;
        uint32_t     mem_vaddr;     // low bits select the load lane in writeback
        logic [3:0]  be;
        inst_fetch_t inst_fetch;
    } pipe_mm_t;

    typedef struct packed {
        logic       read;
        logic       write;
        uint32_t    vaddr;
        logic [3:0] be;
        uint32_t    wrdata;
    } dcache_req_t;

    // Access size of an op; MSZ_NONE for non-memory ops
    function automatic mem_size_t op_size(op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = MSZ_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = MSZ_HALF;
            OP_LW, OP_SW:         op_size = MSZ_WORD;
            default:              op_size = MSZ_NONE;
        endcase
    endfunction

    function automatic logic op_is_load(op_t op);
        op_is_load = (op == OP_LB) || (op == OP_LBU) || (op == OP_LH) ||
                     (op == OP_LHU) || (op == OP_LW);
    endfunction

    function automatic logic op_is_store(op_t op);
        op_is_store = (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    // Byte enables for the access; word ops always enable all four lanes
    function automatic logic [3:0] mem_be(op_t op, logic [1:0] addr);
        case (op_size(op))
            MSZ_BYTE: mem_be = 4'b0001 << addr;
            MSZ_HALF: mem_be = 4'b0011 << addr;
            MSZ_WORD: mem_be = 4'b1111;
            default:  mem_be = 4'b0000;
        endcase
    endfunction

    // Replicate the store operand across every lane it may land in
    function automatic uint32_t store_data(op_t op, uint32_t rt);
        case (op)
            OP_SB:   store_data = {4{rt[7:0]}};
            OP_SH:   store_data = {2{rt[15:0]}};
            OP_SW:   store_data = rt;
            default: store_data = '0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_mm_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : mm_req_gen
// Description : Pure combinational decode of a load/store op and address into
//               dcache read/write strobes, byte enables, lane-replicated store
//               data and an alignment-error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_req_gen
    import inst_mm_pkg::*;
(
    input  logic [4:0]  i_op,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_rt,
    output logic        o_read,
    output logic        o_write,
    output logic [3:0]  o_be,
    output logic [31:0] o_wrdata,
    output logic        o_misaligned
);

    op_t       w_op;
    mem_size_t w_size;

    assign w_op   = op_t'(i_op);
    assign w_size = op_size(w_op);

    // Half-words need bit 0 clear, words need both low bits clear
    assign o_misaligned = ((w_size == MSZ_HALF) && i_addr_lo[0]) ||
                          ((w_size == MSZ_WORD) && (i_addr_lo != 2'b00));

    // A misaligned access never reaches the dcache
    assign o_read   = op_is_load(w_op)  && !o_misaligned;
    assign o_write  = op_is_store(w_op) && !o_misaligned;
    assign o_be     = mem_be(w_op, i_addr_lo);
    assign o_wrdata = store_data(w_op, i_rt);

endmodule
`default_nettype wire

// File: rtl/inst_mm.sv
`default_nettype none
// ============================================================================
// Module      : inst_mm
// Description : Memory-access pipeline stage. Issues the dcache request for
//               the instruction from execute, parks it in a skid register while
//               the dcache is busy, flags address errors and registers the
//               result for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_mm
    import inst_mm_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(uint32_t)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic                           ready_i,
    output logic                           ready_o,
    input  logic [$bits(pipe_ex_t)-1:0]    pipe_ex,
    input  logic                           dcache_busy,
    output logic [$bits(dcache_req_t)-1:0] dcache_req,
    output logic [$bits(pipe_mm_t)-1:0]    pipe_mm_n,
    output logic [$bits(pipe_mm_t)-1:0]    pipe_mm,
    output logic                           exc_valid,
    output logic [4:0]                     exc_code,
    output logic [DATA_WIDTH-1:0]          exc_badvaddr
);

    pipe_ex_t    ex_in;
    pipe_ex_t    src;
    dcache_req_t req;
    pipe_mm_t    mm_n;

    mm_state_t             state_q, state_d;
    pipe_ex_t              skid_q, skid_d;
    pipe_mm_t              pipe_mm_q, pipe_mm_d;
    logic                  exc_valid_q, exc_valid_d;
    logic [4:0]            exc_code_q, exc_code_d;
    logic [DATA_WIDTH-1:0] exc_badvaddr_q, exc_badvaddr_d;

    logic        gen_read;
    logic        gen_write;
    logic [3:0]  gen_be;
    logic [31:0] gen_wrdata;
    logic        gen_misaligned;
    logic        mem_ok;
    logic        issue_ok;

    assign ex_in = pipe_ex_t'(pipe_ex);

    // While holding, the parked copy drives the request so upstream is free
    assign src = (state_q == ST_HOLD) ? skid_q : ex_in;

    mm_req_gen u_req_gen (
        .i_op         (src.decode_resp.op),
        .i_addr_lo    (src.mem_vaddr[1:0]),
        .i_rt         (src.mem_wrdata),
        .o_read       (gen_read),
        .o_write      (gen_write),
        .o_be         (gen_be),
        .o_wrdata     (gen_wrdata),
        .o_misaligned (gen_misaligned)
    );

    assign mem_ok   = gen_read || gen_write;
    assign issue_ok = src.valid && !flush && ready_i;

    // dcache request: strobes are killed by flush, payload always follows src
    always_comb begin
        req        = '0;
        req.read   = issue_ok && gen_read;
        req.write  = issue_ok && gen_write;
        req.vaddr  = src.mem_vaddr;
        req.be     = gen_be;
        req.wrdata = gen_wrdata;
    end

    // Next stage output; an address error must not write the register file
    always_comb begin
        mm_n              = '0;
        mm_n.valid        = src.valid && !flush;
        mm_n.op           = src.decode_resp.op;
        mm_n.regs_wreq    = src.regs_wreq;
        mm_n.regs_wreq.we = src.regs_wreq.we && !gen_misaligned;
        mm_n.mem_vaddr    = src.mem_vaddr;
        mm_n.be           = gen_be;
        mm_n.inst_fetch   = src.inst_fetch;
    end

    // Upstream must stall while a request is held or about to be parked
    always_comb begin
        ready_o = 1'b0;
        if (state_q == ST_IDLE) begin
            ready_o = ready_i && !(mem_ok && dcache_busy && ex_in.valid);
        end
    end

    // Next-state, skid capture and registered outputs; flush beats everything
    always_comb begin
        state_d        = state_q;
        skid_d         = skid_q;
        pipe_mm_d      = '0;
        exc_valid_d    = 1'b0;
        exc_code_d     = '0;
        exc_badvaddr_d = '0;

        if (flush) begin
            state_d = ST_IDLE;
            skid_d  = '0;
        end else if (!ready_i) begin
            // Writeback cannot take anything; emit a bubble and keep state
            pipe_mm_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ex_in.valid && mem_ok && dcache_busy) begin
                        skid_d  = ex_in;
                        state_d = ST_HOLD;
                    end else begin
                        pipe_mm_d = mm_n;
                        if (ex_in.valid && gen_misaligned) begin
                            exc_valid_d    = 1'b1;
                            exc_code_d     = op_is_store(ex_in.decode_resp.op) ?
                                             EXC_ADES : EXC_ADEL;
                            exc_badvaddr_d = ex_in.mem_vaddr;
                        end
                    end
                end
                ST_HOLD: begin
                    // Only aligned requests are ever parked, so no exception here
                    if (!dcache_busy) begin
                        pipe_mm_d = mm_n;
                        skid_d    = '0;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    skid_d  = '0;
                end
            endcase
        end
    end

    // Stage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            skid_q         <= '0;
            pipe_mm_q      <= '0;
            exc_valid_q    <= 1'b0;
            exc_code_q     <= '0;
            exc_badvaddr_q <= '0;
        end else begin
            state_q        <= state_d;
            skid_q         <= skid_d;
            pipe_mm_q      <= pipe_mm_d;
            exc_valid_q    <= exc_valid_d;
            exc_code_q     <= exc_code_d;
            exc_badvaddr_q <= exc_badvaddr_d;
        end
    end

    assign dcache_req   = req;
    assign pipe_mm_n    = mm_n;
    assign pipe_mm      = pipe_mm_q;
    assign exc_valid    = exc_valid_q;
    assign exc_code     = exc_code_q;
    assign exc_badvaddr = exc_badvaddr_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_mm.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_mm
// Description : Self-checking bench for inst_mm: directed cases plus random
//               traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_mm;
    import inst_mm_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        ready_i;
    logic        ready_o;
    pipe_ex_t    pex;
    logic        busy;
    dcache_req_t req;
    pipe_mm_t    mm_n;
    pipe_mm_t    mm;
    logic        exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_badvaddr;

    int tests;
    int fails;

    // Reference model: one optional parked instruction plus expected registers
    logic        m_held;
    pipe_ex_t    m_held_ins;
    pipe_mm_t    e_mm;
    logic        e_exc;
    logic [4:0]  e_code;
    logic [31:0] e_bad;

    inst_mm dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ready_i      (ready_i),
        .ready_o      (ready_o),
        .pipe_ex      (pex),
        .dcache_busy  (busy),
        .dcache_req   (req),
        .pipe_mm_n    (mm_n),
        .pipe_mm      (mm),
        .exc_valid    (exc_valid),
        .exc_code     (exc_code),
        .exc_badvaddr (exc_badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Number of bytes touched by an op (0 for non-memory)
    function automatic int nbytes(op_t op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 1;
            OP_LH, OP_LHU, OP_SH: return 2;
            OP_LW, OP_SW:         return 4;
            default:              return 0;
        endcase
    endfunction

    function automatic logic is_st(op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic bad_align(pipe_ex_t p);
        int n;
        n = nbytes(p.decode_resp.op);
        return (n > 1) && ((p.mem_vaddr % n) != 0);
    endfunction

    function automatic logic [3:0] exp_be(pipe_ex_t p);
        int n;
        logic [7:0] v;
        n = nbytes(p.decode_resp.op);
        if (n == 0) return 4'h0;
        if (n == 4) return 4'hF;
        v = 8'(((1 << n) - 1) << (p.mem_vaddr % 4));
        return v[3:0];
    endfunction

    function automatic logic [31:0] exp_wd(pipe_ex_t p);
        case (p.decode_resp.op)
            OP_SB:   return 32'(p.mem_wrdata[7:0]) * 32'h0101_0101;
            OP_SH:   return 32'(p.mem_wrdata[15:0]) * 32'h0001_0001;
            OP_SW:   return p.mem_wrdata;
            default: return 32'h0;
        endcase
    endfunction

    function automatic pipe_ex_t mk(op_t op, logic [31:0] va, logic [31:0] rt,
                                    logic we, logic [4:0] wa, logic [31:0] wd);
        pipe_ex_t p;
        p                     = '0;
        p.valid               = 1'b1;
        p.decode_resp.op      = op;
        p.regs_wreq.we        = we;
        p.regs_wreq.waddr     = wa;
        p.regs_wreq.wrdata    = wd;
        p.mem_vaddr           = va;
        p.mem_wrdata          = rt;
        p.inst_fetch.pc       = 32'hBFC0_0000 + (va & 32'hFFC);
        p.inst_fetch.inst     = $urandom;
        return p;
    endfunction

    // Apply inputs, check combinational outputs, advance the model
    task automatic drive(input pipe_ex_t p, input logic b, input logic f, input logic r);
        pipe_ex_t s;
        logic     mem, mis, e_rd, e_wr, e_rdy, park;
        pipe_mm_t n;
        pex   = p;
        busy  = b;
        flush = f;
        rst   = r;
        #2;
        s    = m_held ? m_held_ins : p;
        mem  = nbytes(s.decode_resp.op) != 0;
        mis  = bad_align(s);
        e_rd = s.valid && mem && !is_st(s.decode_resp.op) && !mis && !f;
        e_wr = s.valid && is_st(s.decode_resp.op) && !mis && !f;
        park = !m_held && p.valid && mem && !mis && b;
        e_rdy = !m_held && !park;
        check("ready_o", ready_o, e_rdy);
        check("dc_read", req.read, e_rd);
        check("dc_write", req.write, e_wr);
        if (e_rd || e_wr) begin
            check("dc_vaddr", req.vaddr, s.mem_vaddr);
            check("dc_be", req.be, exp_be(s));
        end
        if (e_wr) check("dc_wrdata", req.wrdata, exp_wd(s));
        n                 = '0;
        n.valid           = s.valid && !f;
        n.op              = s.decode_resp.op;
        n.regs_wreq       = s.regs_wreq;
        n.regs_wreq.we    = s.regs_wreq.we && !mis;
        n.mem_vaddr       = s.mem_vaddr;
        n.be              = exp_be(s);
        n.inst_fetch      = s.inst_fetch;
        check("pipe_mm_n", mm_n, n);

        e_mm   = '0;
        e_exc  = 1'b0;
        e_code = 5'd0;
        e_bad  = 32'd0;
        if (r || f) begin
            m_held = 1'b0;
        end else if (m_held) begin
            if (!b) begin
                e_mm   = n;
                m_held = 1'b0;
            end
        end else if (park) begin
            m_held     = 1'b1;
            m_held_ins = p;
        end else begin
            e_mm = n;
            if (p.valid && mis) begin
                e_exc  = 1'b1;
                e_code = is_st(p.decode_resp.op) ? 5'd5 : 5'd4;
                e_bad  = p.mem_vaddr;
            end
        end
    endtask

    task automatic check_regs();
        check("pipe_mm", mm, e_mm);
        check("exc_valid", exc_valid, e_exc);
        check("exc_code", exc_code, e_code);
        check("exc_badvaddr", exc_badvaddr, e_bad);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        check_regs();
    endtask

    op_t ops [13] = '{OP_NOP, OP_ADDU, OP_SUBU, OP_OR, OP_LUI, OP_LB, OP_LBU,
                      OP_LH, OP_LHU, OP_LW, OP_SB, OP_SH, OP_SW};

    initial begin
        pipe_ex_t p;
        pipe_ex_t q;
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        flush   = 1'b0;
        ready_i = 1'b1;
        busy    = 1'b0;
        pex     = '0;
        m_held  = 1'b0;
        m_held_ins = '0;
        e_mm    = '0;
        e_exc   = 1'b0;
        e_code  = 5'd0;
        e_bad   = 32'd0;
        @(posedge clk);
        #1;
        check_regs();

        // SW aligned, dcache free
        drive(mk(OP_SW, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
        check("sw_write", req.write, 1'b1);
        check("sw_be", req.be, 4'b1111);
        check("sw_wrdata", req.wrdata, 32'hDEAD_BEEF);
        tick();
        check("sw_mm_valid", mm.valid, 1'b1);

        // SB to lane 3, LH to upper half
        drive(mk(OP_SB, 32'h8000_0013, 32'h0000_00A5, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
        check("sb_be", req.be, 4'b1000);
        check("sb_wrdata", req.wrdata, 32'hA5A5_A5A5);
        tick();
        drive(mk(OP_LH, 32'h8000_0012, 32'h0, 1'b1, 5'd3, 32'd0), 1'b0, 1'b0, 1'b0);
        check("lh_be", req.be, 4'b1100);
        check("lh_read", req.read, 1'b1);
        tick();

        // Misaligned LW then SH
        drive(mk(OP_LW, 32'h8000_0016, 32'h0, 1'b1, 5'd4, 32'd0), 1'b0, 1'b0, 1'b0);
        check("lw_mis_read", req.read, 1'b0);
        tick();
        check("adel_valid", exc_valid, 1'b1);
        check("adel_code", exc_code, 5'd4);
        check("adel_bad", exc_badvaddr, 32'h8000_0016);
        check("adel_we", mm.regs_wreq.we, 1'b0);
        drive(mk(OP_SH, 32'h8000_0011, 32'h1234, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
        tick();
        check("ades_code", exc_code, 5'd5);
        drive(mk(OP_NOP, 32'h0, 32'h0, 1'b0, 5'd0, 32'd0), 1'b0, 1'b0, 1'b0);
        tick();
        check("exc_one_cycle", exc_valid, 1'b0);

        // LW stalled for 3 busy cycles; upstream changes after the first
        p = mk(OP_LW, 32'h8000_0040, 32'h0, 1'b1, 5'd9, 32'd0);
        q = mk(OP_LW, 32'h8000_0080, 32'h0, 1'b1, 5'd10, 32'd0);
        drive(p, 1'b1, 1'b0, 1'b0);
        check("stall_rdy0", ready_o, 1'b0);
        tick();
        check("bubble0", mm.valid, 1'b0);
        for (int i = 0; i < 2; i++) begin
            drive(q, 1'b1, 1'b0, 1'b0);
            check("stall_rdy", ready_o, 1'b0);
            check("held_vaddr", req.vaddr, 32'h8000_0040);
            tick();
            check("bubble", mm.valid, 1'b0);
        end
        drive(q, 1'b0, 1'b0, 1'b0);
        check("release_vaddr", req.vaddr, 32'h8000_0040);
        tick();
        check("held_lw_out", mm.mem_vaddr, 32'h8000_0040);
        drive(q, 1'b0, 1'b0, 1'b0);
        check("new_accept_rdy", ready_o, 1'b1);
        tick();
        check("new_lw_out", mm.mem_vaddr, 32'h8000_0080);

        // Flush in HOLD on the cycle busy drops
        drive(p, 1'b1, 1'b0, 1'b0);
        tick();
        drive(q, 1'b0, 1'b1, 1'b0);
        check("flush_no_rd", req.read, 1'b0);
        tick();
        check("flush_mm", mm, 144'd0);
        drive(mk(OP_ADDU, 32'h0, 32'h0, 1'b1, 5'd1, 32'd1), 1'b1, 1'b0, 1'b0);
        check("flush_idle_rdy", ready_o, 1'b1);
        tick();

        // Reset in HOLD, then ADDU passes straight through
        drive(p, 1'b1, 1'b0, 1'b0);
        tick();
        drive(q, 1'b1, 1'b0, 1'b1);
        tick();
        check("rst_mm", mm, 144'd0);
        drive(mk(OP_ADDU, 32'h0, 32'h0, 1'b1, 5'd5, 32'd7), 1'b0, 1'b0, 1'b0);
        check("rst_idle_rdy", ready_o, 1'b1);
        tick();
        check("addu_wreq", mm.regs_wreq, {1'b1, 5'd5, 32'd7});

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            p = mk(ops[$urandom_range(0, 12)], $urandom, $urandom,
                   1'($urandom), 5'($urandom), $urandom);
            p.valid = ($urandom_range(0, 9) < 8);
            drive(p, ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 49) == 0));
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
